// File: rtl/mac_feeder_pkg.sv
// mac_feeder_pkg: shared types and latency constants for the MAC operand
// sequencer. The layer controller uses the same constants (and op_cycles)
// to budget how long one dot-product command occupies the MAC.
package mac_feeder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_CLR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int DEF_CLR_LAT = 2;
  localparam int DEF_MAC_LAT = 2;

  // Cycles from accepted start to the done pulse.
  function automatic int op_cycles(input int len, input int clr_lat, input int mac_lat);
    return (len == 0) ? 1 : 3 + clr_lat + len + mac_lat;
  endfunction

endpackage

// File: rtl/mac_feeder.sv
// mac_feeder: turns one dot-product command into the MAC's clear/valid
// pulse protocol. Clears the accumulator, streams len operand pairs from
// the weight (a) and feature (b) memories, waits out the MAC pipeline and
// captures the final sum and overflow flag.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, base_a/b, len      command (sampled only in IDLE)
//   busy, done                status; done is a one-cycle pulse
//   result, result_ovf        float32 dot product and sticky overflow
//   mem_a/b_rd, mem_a/b_addr  read port to operand memories (1-cycle latency)
//   mem_a/b_rdata             read data
//   mac_a/b, mac_a/b_valid    operands to the MAC
//   mac_clear                 one-cycle accumulator clear
//   mac_data_out, mac_overflow  MAC result and overflow flag
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LEN_W   = 10,
  parameter int CLR_LAT = DEF_CLR_LAT,
  parameter int MAC_LAT = DEF_MAC_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              result_ovf,
  output logic              mem_a_rd,
  output logic              mem_b_rd,
  output logic [ADDR_W-1:0] mem_a_addr,
  output logic [ADDR_W-1:0] mem_b_addr,
  input  logic [31:0]       mem_a_rdata,
  input  logic [31:0]       mem_b_rdata,
  output logic [31:0]       mac_a,
  output logic [31:0]       mac_b,
  output logic              mac_a_valid,
  output logic              mac_b_valid,
  output logic              mac_clear,
  input  logic [31:0]       mac_data_out,
  input  logic              mac_overflow
);

  localparam int WMAX   = (CLR_LAT > MAC_LAT) ? CLR_LAT : MAC_LAT;
  localparam int WCNT_W = $clog2(WMAX + 1);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    idx_q, idx_d;      // issue counter, shared by both lanes
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;    // clear-wait / drain counter
  logic [ADDR_W-1:0]   base_a_q, base_a_d, base_b_q, base_b_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [31:0]         result_q, result_d;
  logic                ovf_q, ovf_d;
  logic                vld_q;             // read issued last cycle -> data on rdata now
  logic [31:0]         hold_a_q, hold_b_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wcnt_d   = wcnt_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    len_d    = len_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    // Overflow window: first valid pair through the result sample cycle.
    // Valids cover the pairs, DRAIN covers the pipeline tail.
    if (vld_q || state_q == S_DRAIN) ovf_d = ovf_q | mac_overflow;
    unique case (state_q)
      S_IDLE: if (start) begin
        base_a_d = base_a;
        base_b_d = base_b;
        len_d    = len;
        idx_d    = '0;
        wcnt_d   = '0;
        ovf_d    = 1'b0;
        result_d = '0;
        state_d  = (len == '0) ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        wcnt_d  = '0;
        state_d = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        if (wcnt_q == WCNT_W'(CLR_LAT - 1)) state_d = S_STREAM;
        else wcnt_d = wcnt_q + 1'b1;
      end
      S_STREAM: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == len_q - 1'b1) begin
          wcnt_d  = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Entered the cycle after the last read; the last valid pair is
        // that same cycle, so its sum lands MAC_LAT cycles later.
        if (wcnt_q == WCNT_W'(MAC_LAT)) begin
          result_d = mac_data_out;
          state_d  = S_DONE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      wcnt_q   <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      len_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      vld_q    <= 1'b0;
      hold_a_q <= '0;
      hold_b_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      len_q    <= len_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      vld_q    <= (state_q == S_STREAM);
      if (vld_q) begin
        hold_a_q <= mem_a_rdata;
        hold_b_q <= mem_b_rdata;
      end
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign mac_clear   = (state_q == S_CLEAR);
  assign mem_a_rd    = (state_q == S_STREAM);
  assign mem_b_rd    = (state_q == S_STREAM);
  // Address arithmetic wraps modulo 2^ADDR_W.
  assign mem_a_addr  = base_a_q + ADDR_W'(idx_q);
  assign mem_b_addr  = base_b_q + ADDR_W'(idx_q);
  // The memory's output register is the operand register; hold the last
  // pair when no read data is arriving.
  assign mac_a       = vld_q ? mem_a_rdata : hold_a_q;
  assign mac_b       = vld_q ? mem_b_rdata : hold_b_q;
  assign mac_a_valid = vld_q;
  assign mac_b_valid = vld_q;
  assign result      = result_q;
  assign result_ovf  = ovf_q;

endmodule

// File: tb/tb_mac_feeder.sv
module tb_mac_feeder;
  localparam int CLR_LAT = 2;
  localparam int MAC_LAT = 2;
  localparam int T0      = 2 + CLR_LAT;

  logic        clk = 0, rst = 1, start = 0;
  logic [9:0]  base_a = 0, base_b = 0, len = 0;
  logic        busy, done, result_ovf, mem_a_rd, mem_b_rd;
  logic [31:0] result, mac_a, mac_b, mac_data_out;
  logic [9:0]  mem_a_addr, mem_b_addr;
  logic [31:0] mem_a_rdata = 0, mem_b_rdata = 0;
  logic        mac_a_valid, mac_b_valid, mac_clear, mac_overflow = 0;

  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  int acc_q = 0, dout_q = 0;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  mac_feeder #(.ADDR_W(10), .LEN_W(10), .CLR_LAT(CLR_LAT), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .base_a(base_a), .base_b(base_b), .len(len),
    .busy(busy), .done(done), .result(result), .result_ovf(result_ovf),
    .mem_a_rd(mem_a_rd), .mem_b_rd(mem_b_rd), .mem_a_addr(mem_a_addr), .mem_b_addr(mem_b_addr),
    .mem_a_rdata(mem_a_rdata), .mem_b_rdata(mem_b_rdata), .mac_a(mac_a), .mac_b(mac_b),
    .mac_a_valid(mac_a_valid), .mac_b_valid(mac_b_valid), .mac_clear(mac_clear),
    .mac_data_out(mac_data_out), .mac_overflow(mac_overflow));

  // float32 <-> small integer, exact for |v| < 2^24
  function automatic logic [31:0] enc(input int v);
    int m, p;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'((m << (23 - p)) & 32'h7FFFFF);
    return r;
  endfunction

  function automatic int dec(input logic [31:0] f);
    int e, m;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = int'({1'b1, f[22:0]}) >> (23 - e);
    return f[31] ? -m : m;
  endfunction

  // Operand memories: synchronous read, one-cycle latency.
  always @(posedge clk) begin
    if (mem_a_rd) mem_a_rdata <= mem_a[mem_a_addr];
    if (mem_b_rd) mem_b_rdata <= mem_b[mem_b_addr];
  end

  // Behavioural MAC: accumulate stage then output stage (2-cycle latency).
  always @(posedge clk) begin
    if (rst) begin
      acc_q  <= 0;
      dout_q <= 0;
    end else begin
      if (mac_clear) acc_q <= 0;
      else if (mac_a_valid) acc_q <= acc_q + dec(mac_a) * dec(mac_b);
      dout_q <= acc_q;
    end
  end
  assign mac_data_out = enc(dout_q);

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // One command; k = cycle of a one-cycle mac_overflow pulse (-1 none),
  // stray = cycle of an extra start pulse while busy (-1 none).
  task automatic run_op(input int ba, input int bb, input int ln, input int k, input int stray);
    int c, done_c, nrd, nclr, clr_c, nvld, vfirst, nbusy, vmis, exp_lat, ref_sum;
    logic exp_ovf;
    exp_lat = (ln == 0) ? 1 : 3 + CLR_LAT + ln + MAC_LAT;
    ref_sum = 0;
    for (int i = 0; i < ln; i++)
      ref_sum += dec(mem_a[(ba + i) % 1024]) * dec(mem_b[(bb + i) % 1024]);
    exp_ovf = (ln > 0) && (k >= T0 + 1) && (k <= T0 + ln + MAC_LAT);
    @(negedge clk);
    start = 1; base_a = 10'(ba); base_b = 10'(bb); len = 10'(ln);
    mac_overflow = (k == 0);
    c = 0; done_c = -1; nrd = 0; nclr = 0; clr_c = -1; nvld = 0; vfirst = -1; nbusy = 0; vmis = 0;
    while (done_c < 0 && c < 80) begin
      @(posedge clk); #1;
      c++;
      start = (c == stray);
      mac_overflow = (c == k);
      @(negedge clk);
      if (busy) nbusy++;
      if (mac_clear) begin nclr++; clr_c = c; end
      if (mem_a_rd) begin
        chk("addr_a", mem_a_addr, (ba + nrd) % 1024);
        chk("addr_b", mem_b_addr, (bb + nrd) % 1024);
        nrd++;
      end
      if (mac_a_valid !== mac_b_valid) vmis++;
      if (mac_a_valid) begin
        if (nvld == 0) vfirst = c;
        chk("mac_a", mac_a, mem_a[(ba + nvld) % 1024]);
        chk("mac_b", mac_b, mem_b[(bb + nvld) % 1024]);
        nvld++;
      end
      if (done) done_c = c;
    end
    start = 0;
    mac_overflow = 0;
    chk("latency", done_c, exp_lat);
    chk("rd_cnt", nrd, ln);
    chk("clr_cnt", nclr, (ln != 0) ? 1 : 0);
    chk("vld_cnt", nvld, ln);
    chk("vld_eq", vmis, 0);
    chk("busy_cnt", nbusy, exp_lat);
    chk("result", result, enc(ref_sum));
    chk("ovf", result_ovf, exp_ovf);
    if (ln > 0) begin
      chk("clr_cyc", clr_c, 1);
      chk("vld_first", vfirst, T0 + 1);
      chk("hold_a", mac_a, mem_a[(ba + ln - 1) % 1024]);
    end
  endtask

  initial begin
    int nd, ln, k;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = enc(int'($urandom_range(0, 8)) - 4);
      mem_b[i] = enc(int'($urandom_range(0, 8)) - 4);
    end
    for (int i = 0; i < 4; i++) begin
      mem_a[16 + i] = enc(i + 1);
      mem_b[16 + i] = enc(1);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out", {busy, done, result, result_ovf, mem_a_rd, mem_b_rd, mem_a_addr, mem_b_addr,
                      mac_a, mac_b, mac_a_valid, mac_b_valid, mac_clear}, 0);
    @(posedge clk); #1 rst = 0;

    // 1+2+3+4 = 10.0, stray start at cycle 5 ignored
    run_op(16, 16, 4, -1, 5);
    chk("res_10", result, 32'h41200000);
    // start the cycle after done is accepted
    run_op(300, 700, 5, -1, -1);
    // start during the done cycle is ignored
    start = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    chk("done_start_ign", busy, 0);
    run_op(5, 5, 0, -1, -1);
    run_op(1022, 0, 4, -1, -1);
    run_op(100, 200, 3, T0 + 4, -1);
    chk("ovf_drain", result_ovf, 1);
    run_op(100, 200, 3, -1, -1);
    chk("ovf_clean", result_ovf, 0);

    // reset in the middle of STREAM
    @(negedge clk);
    start = 1; base_a = 10'd40; base_b = 10'd80; len = 10'd6;
    nd = 0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 0;
      if (c == 5) rst = 1;
      @(negedge clk);
      if (done) nd++;
    end
    chk("rst_in_stream", mem_a_rd, 1);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_mid_out", {busy, done, result, result_ovf, mem_a_rd, mem_b_rd, mem_a_addr, mem_b_addr,
                        mac_a, mac_b, mac_a_valid, mac_b_valid, mac_clear}, 0);
    chk("rst_no_done", nd, 0);
    run_op(50, 60, 2, -1, -1);

    for (int r = 0; r < 20; r++) begin
      ln = $urandom_range(0, 12);
      k = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, T0 + ln + MAC_LAT + 2)) : -1;
      run_op($urandom_range(0, 1023), $urandom_range(0, 1023), ln, k, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mac_feeder.md
# mac_feeder

Sequencer that drives the float32 multiply-accumulate unit from the operand side. On `start` it clears the accumulator, streams `len` operand pairs from two single-port read memories (weights and features) into the MAC, waits out the MAC pipeline, and captures the final sum and overflow flag. It sits between the CNN/MFCC layer controller and the MAC, turning one dot-product command into the MAC's valid/clear pulse protocol.

## Interface

- `ADDR_W`, 10, operand memory address width
- `LEN_W`, 10, vector length width
- `CLR_LAT`, 2, cycles after `mac_clear` before the first product may be issued
- `MAC_LAT`, 2, cycles from last valid pair to final `mac_data_out`

Ports:
- `clk`  in  1  clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  command strobe; sampled only in IDLE
- `base_a`, `base_b`  in  ADDR_W  vector start addresses
- `len`  in  LEN_W  number of pairs
- `busy`  out  1  high from the cycle after accepted `start` through the `done` cycle
- `done`  out  1  one-cycle pulse; `result` valid
- `result`  out  32  float32 dot product, held until next accepted `start`
- `result_ovf`  out  1  overflow seen during the operation
- `mem_a_rd`, `mem_b_rd`  out  1  read strobes; read data returns next cycle
- `mem_a_addr`, `mem_b_addr`  out  ADDR_W  read addresses
- `mem_a_rdata`, `mem_b_rdata`  in  32  read data
- `mac_a`, `mac_b`  out  32  operands to MAC
- `mac_a_valid`, `mac_b_valid`  out  1  always driven identically
- `mac_clear`  out  1  one-cycle accumulator clear
- `mac_data_out`  in  32  MAC result
- `mac_overflow`  in  1  MAC overflow flag

## Operation

- States: IDLE, CLEAR, WAIT_CLR, STREAM, DRAIN, DONE.
- IDLE: on `start`, latch `base_a`, `base_b`, `len`; clear `result_ovf`. If `len`==0 -> DONE with `result`=0 (no reads, no `mac_clear`); else -> CLEAR.
- CLEAR: `mac_clear`=1 for exactly one cycle -> WAIT_CLR.
- WAIT_CLR: count CLR_LAT cycles -> STREAM.
- STREAM: one read per cycle, address `base+i` for i=0..len-1, modulo 2^ADDR_W (wraps). Read data is registered into `mac_a`/`mac_b` with valids high the following cycle. After the last read -> DRAIN.
- DRAIN: wait until the last valid pair plus MAC_LAT cycles; sample `mac_data_out` into `result` -> DONE.
- DONE: `done`=1 one cycle -> IDLE.
- `result_ovf` = OR of `mac_overflow` over every cycle from the first valid pair through the sample cycle.
- `start` outside IDLE is ignored; `start` in the cycle `done` is high is ignored.
- Reset values: all outputs 0, state IDLE. Reset mid-operation aborts immediately with no `done` and no `mac_clear`. The MAC is re-cleared by the next command.

## Timing

- `start` is accepted at cycle 0. `mac_clear` goes high at cycle 1. First read at T0 = 2+CLR_LAT.
- Valids are high during cycles T0+1 .. T0+len, contiguous with no bubbles.
- `mac_data_out` is sampled at cycle T0+len+MAC_LAT. `done` and the new `result` appear at T0+len+MAC_LAT+1.
- Start-to-done = 3+CLR_LAT+len+MAC_LAT cycles, or 1 cycle for `len`=0.
- `mem_*_rd` is high exactly `len` cycles per operation. `mac_a`/`mac_b` hold their last value when valid is low.

## Structure

- Shared package `mac_feeder_pkg`: state enum, default CLR_LAT/MAC_LAT constants (also used by the layer controller to budget latency).
- Single flat module. One issue counter is shared by both lanes, a valid delay register, and a drain counter. No sub-module.

## Test plan

- `len`=4, A=[1.0,2.0,3.0,4.0], B=[1.0×4], behavioural 2-cycle MAC model -> `result`=0x41200000, `done` at cycle 11, `mac_clear` only at cycle 1.
- `len`=0 -> `done` at cycle 1, `result`=0, no `mem_*_rd`, no `mac_clear`.
- Second `start` at cycle 5 (busy) -> ignored. `start` the cycle after `done` -> accepted, `mac_clear` reasserted, new result independent of first.
- `base_a`=1022, `base_b`=0, `len`=4 -> `mem_a_addr` sequence 1022,1023,0,1; `mem_b_addr` 0..3.
- Model pulses `mac_overflow` for one cycle during DRAIN -> `result_ovf`=1 at `done`. Next clean command -> `result_ovf`=0.
- `rst` during STREAM -> next cycle all outputs 0, state IDLE, no `done`. Subsequent `len`=2 command completes correctly in 9 cycles.
